// File: rtl/sr_reg_bank.sv
// ----------------------------------------------------------------------------
// sr_reg_bank
// Bank of WIDTH independent set/reset flip-flops with per-channel input
// inversion, optional rising-edge qualification of the requests, selectable
// set/reset conflict rule and a sticky per-channel "changed" flag.
//
// Parameters
//   WIDTH     : number of channels (1..32)
//   RVAL      : value of o while rst is high
//   SET_INV   : per-channel inversion mask applied to set
//   RESET_INV : per-channel inversion mask applied to reset
//   MODE      : set+reset conflict: 0 clear, 1 set, 2 hold, 3 toggle
//   EDGE      : 0 level-sensitive requests, 1 rising-edge-sensitive
//
// Ports
//   clk          : clock, all state moves on its rising edge
//   rst          : asynchronous active-high reset
//   set          : per-channel set request
//   reset        : per-channel clear request (functional, not rst)
//   clr_changed  : per-channel acknowledge of the changed flag
//   o / o_n      : registered channel state and its complement
//   changed      : sticky flag, set whenever o[i] changes value
//   any_changed  : OR of changed
//   count        : number of ones in o
// ----------------------------------------------------------------------------
module sr_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RVAL      = '0,
    parameter logic [WIDTH-1:0] SET_INV   = '0,
    parameter logic [WIDTH-1:0] RESET_INV = '0,
    parameter int               MODE      = 0,
    parameter int               EDGE      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             set,
    input  logic [WIDTH-1:0]             reset,
    input  logic [WIDTH-1:0]             clr_changed,
    output logic [WIDTH-1:0]             o,
    output logic [WIDTH-1:0]             o_n,
    output logic [WIDTH-1:0]             changed,
    output logic                         any_changed,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_o;
    logic [WIDTH-1:0] r_changed;
    logic [WIDTH-1:0] r_s_prev;
    logic [WIDTH-1:0] r_r_prev;

    logic [WIDTH-1:0] w_s_lvl;
    logic [WIDTH-1:0] w_r_lvl;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_both_val;
    logic [WIDTH-1:0] w_o_next;
    logic [WIDTH-1:0] w_chg_next;
    logic [CW-1:0]    w_count;

    assign w_s_lvl = set   ^ SET_INV;
    assign w_r_lvl = reset ^ RESET_INV;

    // In edge mode a request is only seen on the cycle its effective level
    // rises. The previous-level registers are held at all-ones in reset so an
    // input already active at release never looks like a fresh edge.
    assign w_s = w_s_lvl & ~((EDGE != 0) ? r_s_prev : '0);
    assign w_r = w_r_lvl & ~((EDGE != 0) ? r_r_prev : '0);

    // Next value for channels where both requests are active.
    always_comb begin
        w_both_val = '0;
        case (MODE)
            1:       w_both_val = '1;
            2:       w_both_val = r_o;
            3:       w_both_val = ~r_o;
            default: w_both_val = '0;
        endcase
    end

    assign w_o_next = ( w_s & ~w_r)
                    | (~w_s & ~w_r & r_o)
                    | ( w_s &  w_r & w_both_val);

    // A real change of o always wins over an acknowledge on the same edge.
    assign w_chg_next = (w_o_next ^ r_o) | (r_changed & ~clr_changed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o       <= RVAL;
            r_changed <= '0;
            r_s_prev  <= '1;
            r_r_prev  <= '1;
        end else begin
            r_o       <= w_o_next;
            r_changed <= w_chg_next;
            r_s_prev  <= w_s_lvl;
            r_r_prev  <= w_r_lvl;
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < WIDTH; i++)
            w_count = w_count + CW'(r_o[i]);
    end

    assign o           = r_o;
    assign o_n         = ~r_o;
    assign changed     = r_changed;
    assign any_changed = |r_changed;
    assign count       = w_count;

endmodule

// File: tb/tb_sr_reg_bank.sv
// ----------------------------------------------------------------------------
// tb_sr_reg_bank
// Several 4-channel instances with different MODE/EDGE/RVAL/inversion
// settings share one stimulus stream; each is compared against a
// per-channel behavioural model kept in the bench.
// ----------------------------------------------------------------------------
module tb_sr_reg_bank;

    localparam int N = 7;
    localparam int W = 4;

    // Instance configuration, instance g in slice g.
    localparam logic [N*W-1:0] RV_TAB = {4'b0101, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    localparam logic [N*W-1:0] SI_TAB = {4'b0110, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    localparam logic [N*W-1:0] RI_TAB = {4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    localparam logic [N*2-1:0] MD_TAB = {2'd3, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [N-1:0]   ED_TAB = 7'b1100000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] set_i, reset_i, clr_i;

    logic [W-1:0] o_a   [N];
    logic [W-1:0] on_a  [N];
    logic [W-1:0] ch_a  [N];
    logic         any_a [N];
    logic [2:0]   cnt_a [N];

    // Behavioural model state.
    logic [W-1:0] m_o  [N];
    logic [W-1:0] m_ch [N];
    logic [W-1:0] m_sp [N];
    logic [W-1:0] m_rp [N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sr_reg_bank #(
            .WIDTH     (W),
            .RVAL      (RV_TAB[g*W +: W]),
            .SET_INV   (SI_TAB[g*W +: W]),
            .RESET_INV (RI_TAB[g*W +: W]),
            .MODE      (int'(MD_TAB[g*2 +: 2])),
            .EDGE      (int'(ED_TAB[g]))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .set         (set_i),
            .reset       (reset_i),
            .clr_changed (clr_i),
            .o           (o_a[g]),
            .o_n         (on_a[g]),
            .changed     (ch_a[g]),
            .any_changed (any_a[g]),
            .count       (cnt_a[g])
        );
    end

    // ---------------- model ----------------
    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            m_o[g]  = RV_TAB[g*W +: W];
            m_ch[g] = '0;
            m_sp[g] = '1;
            m_rp[g] = '1;
        end
    endtask

    // One clock edge: compute the spec behaviour channel by channel from
    // the inputs present before the edge, then sample #1 after it.
    task automatic cycle();
        logic [W-1:0] no [N];
        logic [W-1:0] nc [N];
        logic [W-1:0] ns [N];
        logic [W-1:0] nr [N];
        for (int g = 0; g < N; g++) begin
            int md;
            md = int'(MD_TAB[g*2 +: 2]);
            for (int i = 0; i < W; i++) begin
                bit s, r, cur, nxt;
                s   = set_i[i]   ^ SI_TAB[g*W + i];
                r   = reset_i[i] ^ RI_TAB[g*W + i];
                ns[g][i] = s;
                nr[g][i] = r;
                if (ED_TAB[g]) begin
                    s = s && !m_sp[g][i];
                    r = r && !m_rp[g][i];
                end
                cur = m_o[g][i];
                if (s && r) begin
                    if (md == 0)      nxt = 1'b0;
                    else if (md == 1) nxt = 1'b1;
                    else if (md == 2) nxt = cur;
                    else              nxt = !cur;
                end else if (s) nxt = 1'b1;
                else if (r)     nxt = 1'b0;
                else            nxt = cur;
                no[g][i] = nxt;
                if (nxt != cur)     nc[g][i] = 1'b1;
                else if (clr_i[i])  nc[g][i] = 1'b0;
                else                nc[g][i] = m_ch[g][i];
            end
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            m_o[g]  = no[g];
            m_ch[g] = nc[g];
            m_sp[g] = ns[g];
            m_rp[g] = nr[g];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        set_i = '0; reset_i = '0; clr_i = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            n_cmp++;
            if (o_a[g] !== m_o[g] || on_a[g] !== ~m_o[g] || ch_a[g] !== 4'b0 ||
                any_a[g] !== 1'b0 || cnt_a[g] !== 3'($countones(m_o[g]))) begin
                n_err++;
                $display("FAIL reset[%0d]: o=%b o_n=%b ch=%b any=%b cnt=%0d, want o=%b o_n=%b ch=0000 any=0 cnt=%0d",
                         g, o_a[g], on_a[g], ch_a[g], any_a[g], cnt_a[g], m_o[g], ~m_o[g], $countones(m_o[g]));
            end
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_basic();
        idle_inputs();
        do_reset();
        set_i = 4'b0011;
        cycle();
        n_cmp++;
        if (o_a[0] !== 4'b0011 || cnt_a[0] !== 3'd2 || ch_a[0] !== 4'b0011 || any_a[0] !== 1'b1) begin
            n_err++;
            $display("FAIL basic_set: o=%b cnt=%0d ch=%b any=%b, want o=0011 cnt=2 ch=0011 any=1",
                     o_a[0], cnt_a[0], ch_a[0], any_a[0]);
        end
        set_i = '0;
        clr_i = 4'b0011;
        cycle();
        n_cmp++;
        if (o_a[0] !== 4'b0011 || ch_a[0] !== 4'b0000 || any_a[0] !== 1'b0) begin
            n_err++;
            $display("FAIL basic_clr: o=%b ch=%b any=%b, want o=0011 ch=0000 any=0",
                     o_a[0], ch_a[0], any_a[0]);
        end
        // A set on a channel already at 1 must not re-raise changed.
        clr_i = '0;
        set_i = 4'b0001;
        cycle();
        n_cmp++;
        if (o_a[0] !== 4'b0011 || ch_a[0] !== 4'b0000) begin
            n_err++;
            $display("FAIL basic_noop: o=%b ch=%b, want o=0011 ch=0000", o_a[0], ch_a[0]);
        end
        idle_inputs();
    endtask

    task automatic test_mode_sweep();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'b000;
        exp_seq[1] = 3'b111;
        exp_seq[2] = 3'b000;
        exp_seq[3] = 3'b101;
        idle_inputs();
        do_reset();
        set_i   = 4'b0001;
        reset_i = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            cycle();
            for (int md = 0; md < 4; md++) begin
                n_cmp++;
                if (o_a[md][0] !== exp_seq[md][2-c]) begin
                    n_err++;
                    $display("FAIL mode%0d_cyc%0d: o[0]=%b, want %b", md, c, o_a[md][0], exp_seq[md][2-c]);
                end
            end
            n_cmp++;
            if (ch_a[3][0] !== 1'b1) begin
                n_err++;
                $display("FAIL mode3_changed_cyc%0d: changed[0]=%b, want 1", c, ch_a[3][0]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_inversion();
        idle_inputs();
        do_reset();
        cycle();
        n_cmp++;
        if (o_a[4][2] !== 1'b1) begin
            n_err++;
            $display("FAIL inv_set_idle: o[2]=%b, want 1", o_a[4][2]);
        end
        set_i   = 4'b0100;
        reset_i = 4'b0100;
        cycle();
        n_cmp++;
        if (o_a[4][2] !== 1'b0) begin
            n_err++;
            $display("FAIL inv_set_reset: o[2]=%b, want 0", o_a[4][2]);
        end
        idle_inputs();
    endtask

    task automatic test_edge();
        idle_inputs();
        do_reset();
        cycle();
        reset_i = 4'b0010;
        cycle();
        reset_i = '0;
        n_cmp++;
        if (o_a[5] !== 4'b1000) begin
            n_err++;
            $display("FAIL edge_clear: o=%b, want 1000", o_a[5]);
        end
        set_i = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_cmp++;
            if (o_a[5][1] !== 1'b1 || ch_a[5][1] !== 1'b1) begin
                n_err++;
                $display("FAIL edge_hold_set_cyc%0d: o[1]=%b ch[1]=%b, want 1 1", c, o_a[5][1], ch_a[5][1]);
            end
        end
        reset_i = 4'b0010;
        cycle();
        reset_i = '0;
        n_cmp++;
        if (o_a[5][1] !== 1'b0) begin
            n_err++;
            $display("FAIL edge_reset_pulse: o[1]=%b, want 0", o_a[5][1]);
        end
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_cmp++;
            if (o_a[5][1] !== 1'b0) begin
                n_err++;
                $display("FAIL edge_stale_set_cyc%0d: o[1]=%b, want 0", c, o_a[5][1]);
            end
        end
        set_i = '0;
        cycle();
        set_i = 4'b0010;
        cycle();
        n_cmp++;
        if (o_a[5][1] !== 1'b1) begin
            n_err++;
            $display("FAIL edge_fresh_set: o[1]=%b, want 1", o_a[5][1]);
        end
        idle_inputs();
    endtask

    task automatic test_clr_vs_toggle();
        idle_inputs();
        do_reset();
        set_i   = 4'b0001;
        reset_i = 4'b0001;
        cycle();
        clr_i = 4'b0001;
        cycle();
        n_cmp++;
        if (o_a[3][0] !== 1'b0 || ch_a[3][0] !== 1'b1 || any_a[3] !== 1'b1) begin
            n_err++;
            $display("FAIL clr_vs_toggle: o[0]=%b ch[0]=%b any=%b, want 0 1 1", o_a[3][0], ch_a[3][0], any_a[3]);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        do_reset();
        set_i = 4'b1111;
        cycle();
        cycle();
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (o_a[5] !== 4'b1010 || cnt_a[5] !== 3'd2 || ch_a[5] !== 4'b0000 || any_a[5] !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: o=%b cnt=%0d ch=%b any=%b, want 1010 2 0000 0",
                     o_a[5], cnt_a[5], ch_a[5], any_a[5]);
        end
        for (int g = 0; g < N; g++) begin
            n_cmp++;
            if (o_a[g] !== m_o[g] || ch_a[g] !== 4'b0000) begin
                n_err++;
                $display("FAIL async_rst[%0d]: o=%b ch=%b, want o=%b ch=0000", g, o_a[g], ch_a[g], m_o[g]);
            end
        end
        @(posedge clk);
        #3 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_cmp++;
            if (o_a[5] !== 4'b1010 || ch_a[5] !== 4'b0000) begin
                n_err++;
                $display("FAIL async_release_edge_cyc%0d: o=%b ch=%b, want 1010 0000", c, o_a[5], ch_a[5]);
            end
            for (int g = 0; g < N; g++) begin
                n_cmp++;
                if (o_a[g] !== m_o[g] || ch_a[g] !== m_ch[g]) begin
                    n_err++;
                    $display("FAIL async_release[%0d]_cyc%0d: o=%b ch=%b, want o=%b ch=%b",
                             g, c, o_a[g], ch_a[g], m_o[g], m_ch[g]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        idle_inputs();
        do_reset();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                set_i   = W'($urandom) & W'($urandom);
                reset_i = W'($urandom) & W'($urandom);
                clr_i   = W'($urandom_range(0, 3) == 0 ? $urandom : 0);
                cycle();
            end
            for (int g = 0; g < N; g++) begin
                n_cmp++;
                if (o_a[g] !== m_o[g] || on_a[g] !== ~m_o[g] || ch_a[g] !== m_ch[g] ||
                    any_a[g] !== (|m_ch[g]) || cnt_a[g] !== 3'($countones(m_o[g]))) begin
                    n_err++;
                    $display("FAIL rand[%0d]_it%0d: o=%b o_n=%b ch=%b any=%b cnt=%0d, want o=%b ch=%b cnt=%0d",
                             g, it, o_a[g], on_a[g], ch_a[g], any_a[g], cnt_a[g],
                             m_o[g], m_ch[g], $countones(m_o[g]));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mode_sweep();
        test_inversion();
        test_edge();
        test_clr_vs_toggle();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
